dm_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between the CPU MEM stage (port `cpu_`) and the program/data loader (port `ldr_`). It supports an optional loader burst lock and returns read data to the correct requester one cycle after grant, matching the memory's registered read. It sits between the MEM stage/loader and DM, and stalls the pipeline when the CPU loses arbitration.

---
 rtl/dm_arbiter_pkg.sv | 30 +++
 rtl/dm_arbiter_if.sv | 45 ++++
 rtl/dm_arb_starve_cnt.sv | 37 +++
 rtl/dm_arbiter.sv | 112 +++++++++++
 tb/tb_dm_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared control encodings for the data-memory arbiter: FSM states, return-port tags,
// DM enable encodings and the read-return tag record.
package dm_arbiter_pkg;

    localparam logic [0:0] ARB_FREE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    localparam logic ARB_PORT_CPU = 1'b0;
    localparam logic ARB_PORT_LDR = 1'b1;

    localparam logic DM_R_ON  = 1'b1;
    localparam logic DM_R_OFF = 1'b0;
    localparam logic DM_W_ON  = 1'b1;
    localparam logic DM_W_OFF = 1'b0;

    localparam int STARVE_CNT_W = 8;

    typedef struct packed {
        logic valid;
        logic port;
    } rtag_t;

    function automatic rtag_t make_rtag(input logic valid, input logic port);
        rtag_t t;
        t.valid = valid;
        t.port  = port;
        return t;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of CPU, loader and DM-side signals around the arbiter.
// slave = arbiter view; master = requesters plus memory view.
interface dm_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    logic        ldr_req;
    logic        ldr_we;
    logic        ldr_lock;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [31:0] ldr_rdata;

    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output dm_addr, dm_wdata, dm_r, dm_w,
        input  dm_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  dm_addr, dm_wdata, dm_r, dm_w,
        output dm_rdata
    );
endinterface

// File: rtl/dm_arb_starve_cnt.sv
// Loader starvation counter: counts lost contests, saturates at STARVE_MAX and
// raises force_ldr so the loader wins the next simultaneous request.
module dm_arb_starve_cnt
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic cnt_clr,
    output logic force_ldr
);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_ldr = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter (CPU MEM stage vs loader) in front of the single-ported data memory.
// Optional loader anti-starvation enabled by defining DM_ARB_STARVE_EN.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    dm_arbiter_if.slave    bus
);
    logic [0:0]  state_q, state_d;
    rtag_t       rtag_q, rtag_d;
    logic        force_ldr;
    logic        cpu_gnt, ldr_gnt;
    logic        rd_gnt;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_r, dm_w;
    logic        cpu_rvalid, ldr_rvalid;

    // Grants are suppressed while rst is high so no access can start in a reset cycle.
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (!rst) begin
            if (state_q == ARB_LOCK) begin
                ldr_gnt = bus.ldr_req;
            end else if (bus.cpu_req && bus.ldr_req) begin
                ldr_gnt = force_ldr;
                cpu_gnt = !force_ldr;
            end else begin
                cpu_gnt = bus.cpu_req;
                ldr_gnt = bus.ldr_req;
            end
        end
    end

    always_comb begin
        dm_addr  = '0;
        dm_wdata = '0;
        dm_r     = DM_R_OFF;
        dm_w     = DM_W_OFF;
        rd_gnt   = 1'b0;
        if (cpu_gnt) begin
            dm_addr  = bus.cpu_addr;
            dm_wdata = bus.cpu_wdata;
            dm_r     = bus.cpu_we ? DM_R_OFF : DM_R_ON;
            dm_w     = bus.cpu_we ? DM_W_ON  : DM_W_OFF;
            rd_gnt   = !bus.cpu_we;
        end else if (ldr_gnt) begin
            dm_addr  = bus.ldr_addr;
            dm_wdata = bus.ldr_wdata;
            dm_r     = bus.ldr_we ? DM_R_OFF : DM_R_ON;
            dm_w     = bus.ldr_we ? DM_W_ON  : DM_W_OFF;
            rd_gnt   = !bus.ldr_we;
        end
    end

    // Lock is entered on a locked loader grant and left one cycle after lock drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_FREE: if (ldr_gnt && bus.ldr_lock) state_d = ARB_LOCK;
            ARB_LOCK: if (!bus.ldr_lock)           state_d = ARB_FREE;
            default:                               state_d = ARB_FREE;
        endcase
        rtag_d = make_rtag(rd_gnt, ldr_gnt ? ARB_PORT_LDR : ARB_PORT_CPU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_FREE;
            rtag_q  <= make_rtag(1'b0, ARB_PORT_CPU);
        end else begin
            state_q <= state_d;
            rtag_q  <= rtag_d;
        end
    end

`ifdef DM_ARB_STARVE_EN
    dm_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    ((state_q == ARB_FREE) && bus.ldr_req && !ldr_gnt),
        .cnt_clr   (ldr_gnt || !bus.ldr_req),
        .force_ldr (force_ldr)
    );
`else
    logic unused_starve_cfg;
    assign force_ldr         = 1'b0;
    assign unused_starve_cfg = ^STARVE_CNT_W'(STARVE_MAX);
`endif

    // The tag captured before a reset must not leak out during the reset cycle.
    assign cpu_rvalid = !rst && rtag_q.valid && (rtag_q.port == ARB_PORT_CPU);
    assign ldr_rvalid = !rst && rtag_q.valid && (rtag_q.port == ARB_PORT_LDR);

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.dm_rdata : '0;
    assign bus.ldr_gnt    = ldr_gnt;
    assign bus.ldr_rvalid = ldr_rvalid;
    assign bus.ldr_rdata  = ldr_rvalid ? bus.dm_rdata : '0;
    assign bus.dm_addr    = dm_addr;
    assign bus.dm_wdata   = dm_wdata;
    assign bus.dm_r       = dm_r;
    assign bus.dm_w       = dm_w;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a registered-read memory model on the DM side.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int STARVE = 3;
`ifdef DM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dm_arbiter_if bus ();

    dm_arbiter #(
        .STARVE_MAX (STARVE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: preloaded while in reset, registered read, write at clock edge.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[4] <= 32'hDEAD_BEEF;
        end else begin
            if (bus.dm_w == DM_W_ON) mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
            if (bus.dm_r == DM_R_ON) bus.dm_rdata <= mem[bus.dm_addr[7:2]];
        end
    end

    function automatic logic [4:0] ctl_now();
        return {bus.cpu_gnt, bus.ldr_gnt, bus.cpu_stall, bus.dm_r, bus.dm_w};
    endfunction

    function automatic logic [1:0] rv_now();
        return {bus.cpu_rvalid, bus.ldr_rvalid};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic lr, input logic lw, input logic ll,
                         input logic [31:0] la, input logic [31:0] ld);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.ldr_req   = lr;
        bus.ldr_we    = lw;
        bus.ldr_lock  = ll;
        bus.ldr_addr  = la;
        bus.ldr_wdata = ld;
    endtask

    task automatic test_reset();
        logic [4:0] c;
        rst = 1'b1;
        drive(1, 0, 32'h10, 0, 1, 0, 1, 32'h20, 0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            #2;
            c = ctl_now();
            n_cmp++;
            if (c !== 5'b00100) begin
                n_err++;
                $display("FAIL reset_ctl[%0d]: got %b want 00100", k, c);
            end
            n_cmp++;
            if ({rv_now(), bus.cpu_rdata, bus.ldr_rdata} !== 66'd0) begin
                n_err++;
                $display("FAIL reset_ret[%0d]: rv=%b cpu_rdata=%h ldr_rdata=%h want all 0",
                         k, rv_now(), bus.cpu_rdata, bus.ldr_rdata);
            end
        end
        cyc();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("reset: grants held off, stall follows cpu_req");
    endtask

    task automatic test_cpu_read();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({ctl_now(), bus.dm_addr} !== {5'b10010, 32'h10}) begin
            n_err++;
            $display("FAIL cpu_read_gnt: ctl=%b addr=%h want 10010 00000010", ctl_now(), bus.dm_addr);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({rv_now(), bus.cpu_rdata, bus.ldr_rdata} !== {2'b10, 32'hDEAD_BEEF, 32'h0}) begin
            n_err++;
            $display("FAIL cpu_read_ret: rv=%b cpu=%h ldr=%h want 10 deadbeef 0",
                     rv_now(), bus.cpu_rdata, bus.ldr_rdata);
        end
        $display("cpu_read: addr 0x10 -> %h", bus.cpu_rdata);
        cyc();
    endtask

    task automatic test_starve();
        logic [4:0]  exp_c;
        logic [65:0] exp_r;
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
        for (int k = 1; k <= 5; k++) begin
            #2;
            exp_c = (STARVE_ON && k == 4) ? 5'b01101 : 5'b10010;
            n_cmp++;
            if (ctl_now() !== exp_c) begin
                n_err++;
                $display("FAIL starve_ctl[%0d]: got %b want %b", k, ctl_now(), exp_c);
            end
            $display("starve cycle %0d: cpu_gnt=%b ldr_gnt=%b", k, bus.cpu_gnt, bus.ldr_gnt);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        // Cycle 5 was a CPU read of 0x10 in both builds
        exp_r = {2'b10, 32'hDEAD_BEEF, 32'h0};
        n_cmp++;
        if ({rv_now(), bus.cpu_rdata, bus.ldr_rdata} !== exp_r) begin
            n_err++;
            $display("FAIL starve_ret: rv=%b cpu=%h ldr=%h want %b %h %h",
                     rv_now(), bus.cpu_rdata, bus.ldr_rdata, exp_r[65:64], exp_r[63:32], exp_r[31:0]);
        end
        cyc();
    endtask

    task automatic test_lock();
        logic [4:0] exp_c [6];
        exp_c = '{5'b01001, 5'b01101, 5'b01101, 5'b00100, 5'b00100, 5'b10010};
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       drive(0, 0, 32'h4, 0, 1, 1, 1, 32'h0, 32'h1);
                1:       drive(1, 0, 32'h4, 0, 1, 1, 1, 32'h4, 32'h2);
                2:       drive(1, 0, 32'h4, 0, 1, 1, 1, 32'h8, 32'h3);
                3:       drive(1, 0, 32'h4, 0, 0, 0, 1, 32'h0, 32'h0);
                default: drive(1, 0, 32'h4, 0, 0, 0, 0, 32'h0, 32'h0);
            endcase
            #2;
            n_cmp++;
            if (ctl_now() !== exp_c[k]) begin
                n_err++;
                $display("FAIL lock_ctl[%0d]: got %b want %b", k, ctl_now(), exp_c[k]);
            end
            $display("lock cycle %0d: cpu_stall=%b ldr_gnt=%b dm_w=%b", k, bus.cpu_stall, bus.ldr_gnt, bus.dm_w);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({rv_now(), bus.cpu_rdata} !== {2'b10, 32'h2}) begin
            n_err++;
            $display("FAIL lock_readback: rv=%b cpu_rdata=%h want 10 00000002", rv_now(), bus.cpu_rdata);
        end
        cyc();
    endtask

    task automatic test_alternate();
        logic [31:0] addr [4];
        logic [31:0] data [4];
        logic        port [4];
        addr = '{32'h10, 32'h20, 32'h30, 32'h34};
        data = '{32'hDEAD_BEEF, 32'h1000_0008, 32'h1000_000C, 32'h1000_000D};
        port = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                if (port[k]) drive(0, 0, 0, 0, 1, 0, 0, addr[k], 0);
                else         drive(1, 0, addr[k], 0, 0, 0, 0, 0, 0);
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            #2;
            if (k < 4) begin
                n_cmp++;
                if (ctl_now() !== (port[k] ? 5'b01010 : 5'b10010)) begin
                    n_err++;
                    $display("FAIL alt_gnt[%0d]: got %b want %b", k, ctl_now(),
                             port[k] ? 5'b01010 : 5'b10010);
                end
            end
            if (k > 0) begin
                n_cmp++;
                if ({rv_now(), bus.cpu_rdata, bus.ldr_rdata} !==
                    (port[k-1] ? {2'b01, 32'h0, data[k-1]} : {2'b10, data[k-1], 32'h0})) begin
                    n_err++;
                    $display("FAIL alt_ret[%0d]: rv=%b cpu=%h ldr=%h want port %0d data %h",
                             k, rv_now(), bus.cpu_rdata, bus.ldr_rdata, port[k-1], data[k-1]);
                end
                $display("alt cycle %0d: rv=%b cpu=%h ldr=%h", k, rv_now(), bus.cpu_rdata, bus.ldr_rdata);
            end
            cyc();
        end
    endtask

    task automatic test_write_read();
        drive(1, 1, 32'h40, 32'h1234_5678, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({ctl_now(), bus.dm_wdata} !== {5'b10001, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL wr_issue: ctl=%b wdata=%h want 10001 12345678", ctl_now(), bus.dm_wdata);
        end
        cyc();
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({ctl_now(), rv_now()} !== {5'b10010, 2'b00}) begin
            n_err++;
            $display("FAIL wr_no_rvalid: ctl=%b rv=%b want 10010 00", ctl_now(), rv_now());
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({rv_now(), bus.cpu_rdata} !== {2'b10, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL raw_readback: rv=%b cpu_rdata=%h want 10 12345678", rv_now(), bus.cpu_rdata);
        end
        $display("write_read: 0x40 -> %h", bus.cpu_rdata);
        cyc();
    endtask

    task automatic test_reset_lock();
        drive(0, 0, 0, 0, 1, 0, 1, 32'h20, 0);
        #2;
        n_cmp++;
        if (ctl_now() !== 5'b01010) begin
            n_err++;
            $display("FAIL rl_lock_gnt: got %b want 01010", ctl_now());
        end
        cyc();
        rst = 1'b1;
        drive(1, 0, 32'h10, 0, 1, 0, 1, 32'h20, 0);
        #2;
        n_cmp++;
        if ({ctl_now(), rv_now(), bus.ldr_rdata} !== {5'b00100, 2'b00, 32'h0}) begin
            n_err++;
            $display("FAIL rl_in_reset: ctl=%b rv=%b ldr_rdata=%h want 00100 00 0",
                     ctl_now(), rv_now(), bus.ldr_rdata);
        end
        cyc();
        rst = 1'b0;
        #2;
        n_cmp++;
        if ({ctl_now(), rv_now()} !== {5'b10010, 2'b00}) begin
            n_err++;
            $display("FAIL rl_after_reset: ctl=%b rv=%b want 10010 00", ctl_now(), rv_now());
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({rv_now(), bus.cpu_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL rl_readback: rv=%b cpu_rdata=%h want 10 deadbeef", rv_now(), bus.cpu_rdata);
        end
        $display("reset_lock: cpu won after reset, rdata=%h", bus.cpu_rdata);
        cyc();
    endtask

    task automatic test_withdraw();
        logic [4:0] exp_c;
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
        cyc();
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({ctl_now(), bus.dm_addr} !== {5'b00000, 32'h0}) begin
            n_err++;
            $display("FAIL wd_no_access: ctl=%b addr=%h want 00000 0", ctl_now(), bus.dm_addr);
        end
        cyc();
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
        for (int k = 1; k <= 4; k++) begin
            #2;
            exp_c = (STARVE_ON && k == 4) ? 5'b01101 : 5'b10010;
            n_cmp++;
            if (ctl_now() !== exp_c) begin
                n_err++;
                $display("FAIL wd_recount[%0d]: got %b want %b", k, ctl_now(), exp_c);
            end
            $display("withdraw recount %0d: cpu_gnt=%b ldr_gnt=%b", k, bus.cpu_gnt, bus.ldr_gnt);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_cpu_read();
        test_starve();
        test_lock();
        test_alternate();
        test_write_read();
        test_reset_lock();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
